// File: rtl/maxpool_if.sv
// Sequencer, data-FIFO and write-back-FIFO signals of the max-pooling engine.
// master = sequencer/FIFO side, slave = maxpool engine.
interface maxpool_if;
    logic        maxpool_ready;
    logic [7:0]  kernel_size;
    logic [31:0] op_num;
    logic [15:0] data_in;
    logic        data_fifo_empty;
    logic        data_fifo_rd_en;
    logic        out_fifo_full;
    logic        out_fifo_wr_en;
    logic [15:0] data_out;
    logic        maxpool_valid;

    modport master (
        output maxpool_ready, kernel_size, op_num, data_in, data_fifo_empty, out_fifo_full,
        input  data_fifo_rd_en, out_fifo_wr_en, data_out, maxpool_valid
    );

    modport slave (
        input  maxpool_ready, kernel_size, op_num, data_in, data_fifo_empty, out_fifo_full,
        output data_fifo_rd_en, out_fifo_wr_en, data_out, maxpool_valid
    );
endinterface

// File: rtl/maxpool.sv
// FP16 max-pool: one max per kernel_size^2 window, win_len+2 cycles/window, done level on maxpool_valid.
// Reads stall on data_fifo_empty; WRITE holds with data_out stable while out_fifo_full.
module maxpool (
    input  logic      clk,
    input  logic      rst_n,
    maxpool_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] win_len;
    logic [15:0] rd_issued;
    logic [15:0] rd_recv;
    logic [15:0] acc;
    logic [31:0] op_num_q;
    logic [31:0] win_cnt;
    logic        rd_pend;
    logic        valid_q;
    logic [15:0] ks_sq;
    logic        rd_en;
    logic        wr_en;

    // Sign-magnitude compare; +0 and -0 tie, NaN/Inf are not special-cased.
    function automatic logic fp16_gt(input logic [15:0] cand, input logic [15:0] ref_v);
        if (cand[15] != ref_v[15])
            return !cand[15] && ((cand[14:0] | ref_v[14:0]) != 15'd0);
        else if (!cand[15])
            return cand[14:0] > ref_v[14:0];
        else
            return cand[14:0] < ref_v[14:0];
    endfunction

    assign ks_sq = {8'd0, bus.kernel_size} * {8'd0, bus.kernel_size};

    // Strobes are combinational so they can never fire against a same-cycle empty/full.
    assign rd_en = (state == ACCUM) && bus.maxpool_ready && !bus.data_fifo_empty
                   && (rd_issued < win_len);
    assign wr_en = (state == WRITE) && bus.maxpool_ready && !bus.out_fifo_full;

    assign bus.data_fifo_rd_en = rd_en;
    assign bus.out_fifo_wr_en  = wr_en;
    assign bus.data_out        = acc;
    assign bus.maxpool_valid   = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_len   <= 16'd0;
            rd_issued <= 16'd0;
            rd_recv   <= 16'd0;
            acc       <= 16'd0;
            op_num_q  <= 32'd0;
            win_cnt   <= 32'd0;
            rd_pend   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_pend <= 1'b0;
                    valid_q <= 1'b0;
                    if (bus.maxpool_ready) begin
                        win_len   <= ks_sq;
                        op_num_q  <= bus.op_num;
                        rd_issued <= 16'd0;
                        rd_recv   <= 16'd0;
                        win_cnt   <= 32'd0;
                        if (ks_sq == 16'd0 || bus.op_num == 32'd0)
                            state <= DONE;
                        else
                            state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!bus.maxpool_ready) begin
                        // Abort: any read still in flight is dropped.
                        rd_pend <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        rd_pend <= rd_en;
                        if (rd_en)
                            rd_issued <= rd_issued + 16'd1;
                        if (rd_pend) begin
                            if (rd_recv == 16'd0 || fp16_gt(bus.data_in, acc))
                                acc <= bus.data_in;
                            rd_recv <= rd_recv + 16'd1;
                            if (rd_recv + 16'd1 == win_len)
                                state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    rd_pend <= 1'b0;
                    if (!bus.maxpool_ready) begin
                        state <= IDLE;
                    end else if (wr_en) begin
                        win_cnt <= win_cnt + 32'd1;
                        if (win_cnt + 32'd1 == op_num_q) begin
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            rd_issued <= 16'd0;
                            rd_recv   <= 16'd0;
                            state     <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    rd_pend <= 1'b0;
                    if (!bus.maxpool_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool.sv
// Directed-vector bench for maxpool: FIFO models, scoreboard queue and an independent write monitor.
module tb_maxpool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    maxpool_if bus();

    maxpool dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int t0 = 0;
    int rd_total = 0;
    int wr_total = 0;
    int viol = 0;
    int last_wr_cyc = -1;
    bit gap_en = 1'b0;
    bit force_full = 1'b0;
    bit took = 1'b0;
    logic [15:0] data_q[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk++;
        if (act !== exp_v) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Data FIFO (standard mode: element appears the cycle after the strobe) and write-back FIFO.
    initial begin
        bus.data_in         = 16'd0;
        bus.data_fifo_empty = 1'b1;
        bus.out_fifo_full   = 1'b0;
        forever begin
            @(negedge clk);
            if (took && data_q.size() > 0)
                bus.data_in = data_q.pop_front();
            bus.data_fifo_empty = (data_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
            bus.out_fifo_full   = force_full || (gap_en && $urandom_range(0, 2) == 0);
            #3;
            took = bus.data_fifo_rd_en && !bus.data_fifo_empty;
        end
    end

    // Monitor: counts strobes, flags protocol violations, scores each write.
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst_n) continue;
        if (bus.data_fifo_rd_en) begin
            rd_total++;
            if (bus.data_fifo_empty) viol++;
        end
        if (bus.out_fifo_wr_en) begin
            wr_total++;
            last_wr_cyc = cyc - t0;
            if (bus.out_fifo_full) viol++;
            if (exp_q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL unexpected_write: data_out=0x%04h but no result expected", bus.data_out);
            end else begin
                check("write_data", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic start(input logic [7:0] ks, input logic [31:0] n);
        @(negedge clk);
        bus.kernel_size   = ks;
        bus.op_num        = n;
        bus.maxpool_ready = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_valid(input string name, input int exp_cyc);
        int got;
        got = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #3;
            if (bus.maxpool_valid) begin
                got = cyc - t0;
                break;
            end
        end
        if (got < 0) begin
            chk++;
            err++;
            $display("FAIL %s_timeout: maxpool_valid low after 600 cycles, required high", name);
        end else if (exp_cyc >= 0) begin
            check({name, "_valid_cycle"}, got, exp_cyc);
        end
    endtask

    task automatic job(input string name, input logic [7:0] ks, input logic [31:0] n,
                       input int exp_rd, input int exp_wr, input int exp_vcyc);
        int rd0, wr0, v0;
        rd0 = rd_total;
        wr0 = wr_total;
        v0  = viol;
        start(ks, n);
        wait_valid(name, exp_vcyc);
        @(negedge clk);
        bus.maxpool_ready = 1'b0;
        @(negedge clk);
        #3;
        check({name, "_valid_dropped"}, bus.maxpool_valid, 0);
        check({name, "_reads"}, rd_total - rd0, exp_rd);
        check({name, "_writes"}, wr_total - wr0, exp_wr);
        check({name, "_protocol_viol"}, viol - v0, 0);
        check({name, "_results_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.maxpool_ready = 1'b0;
        bus.kernel_size   = 8'd0;
        bus.op_num        = 32'd0;
        repeat (3) @(negedge clk);
        #3;
        check("reset_rd_en", bus.data_fifo_rd_en, 0);
        check("reset_wr_en", bus.out_fifo_wr_en, 0);
        check("reset_data_out", bus.data_out, 0);
        check("reset_valid", bus.maxpool_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 3x3 window
        data_q = {16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h0000,
                  16'hC000, 16'h4100, 16'h3E00, 16'h4400};
        exp_q.push_back(16'h4400);
        job("single", 8'd3, 32'd1, 9, 1, 12);
        check("single_wr_cycle", last_wr_cyc, 11);

        // All-negative window
        data_q = {16'hC400, 16'hBC00, 16'hC000, 16'hC200, 16'hC800,
                  16'hBE00, 16'hC100, 16'hC600, 16'hC500};
        exp_q.push_back(16'hBC00);
        job("neg", 8'd3, 32'd1, 9, 1, 12);

        // Signed zeros: first occurrence wins
        data_q = {16'h8000, 16'h0000, 16'h0000, 16'h8000,
                  16'h0000, 16'h8000, 16'h8000, 16'h0000};
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0000);
        job("zeros", 8'd2, 32'd2, 8, 2, 13);

        // Four windows with random empty/full gaps
        data_q = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009,
                  16'h7C00, 16'h3C00, 16'h4000, 16'h0000, 16'h8000, 16'hFC00, 16'h7BFF, 16'h4500, 16'h1234,
                  16'hBC00, 16'h8001, 16'h3555, 16'h3556, 16'h7E00, 16'h3557, 16'hFFFF, 16'h0000, 16'h7DFF,
                  16'hC000, 16'hBC00, 16'h8400, 16'h8000, 16'h0000, 16'hC400, 16'h8001, 16'hFC00, 16'hBFFF};
        exp_q = {16'h0009, 16'h7C00, 16'h7E00, 16'h8000};
        gap_en = 1'b1;
        job("multi", 8'd3, 32'd4, 36, 4, -1);
        gap_en = 1'b0;

        // Degenerate jobs: data available but must not be read
        data_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                  16'h6666, 16'h7777, 16'h1234, 16'h4321};
        job("op0", 8'd3, 32'd0, 0, 0, 2);
        job("ks0", 8'd0, 32'd2, 0, 0, 2);
        data_q.delete();

        // Abort mid-ACCUM
        data_q = {16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h0000,
                  16'hC000, 16'h4100, 16'h3E00, 16'h4400};
        start(8'd3, 32'd1);
        repeat (4) @(negedge clk);
        bus.maxpool_ready = 1'b0;
        @(negedge clk);
        #3;
        check("abort_state_idle", 32'(dut.state), 0);
        check("abort_valid", bus.maxpool_valid, 0);
        check("abort_wr_en", bus.out_fifo_wr_en, 0);
        repeat (15) @(negedge clk);
        #3;
        check("abort_valid_later", bus.maxpool_valid, 0);
        data_q.delete();
        @(negedge clk);
        data_q = {16'h5000, 16'h4FFF, 16'hD000, 16'h5001, 16'h0400,
                  16'h5001, 16'h3000, 16'h2000, 16'h1000};
        exp_q.push_back(16'h5001);
        job("restart", 8'd3, 32'd1, 9, 1, 12);

        // Reset while WRITE is held by a full output FIFO
        data_q = {16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h0000,
                  16'hC000, 16'h4100, 16'h3E00, 16'h4400};
        force_full = 1'b1;
        start(8'd3, 32'd1);
        repeat (13) @(negedge clk);
        #3;
        check("held_wr_en", bus.out_fifo_wr_en, 0);
        check("held_data_out", bus.data_out, 16'h4400);
        @(negedge clk);
        rst_n = 1'b0;
        bus.maxpool_ready = 1'b0;
        #1;
        check("rst_data_out", bus.data_out, 0);
        check("rst_valid", bus.maxpool_valid, 0);
        check("rst_rd_en", bus.data_fifo_rd_en, 0);
        check("rst_wr_en", bus.out_fifo_wr_en, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_full = 1'b0;
        @(negedge clk);
        #3;
        check("post_rst_state", 32'(dut.state), 0);
        check("post_rst_rd_issued", dut.rd_issued, 0);
        check("post_rst_rd_recv", dut.rd_recv, 0);
        check("post_rst_win_cnt", dut.win_cnt, 0);
        data_q.delete();
        @(negedge clk);

        // Fresh job after reset
        data_q = {16'h0000, 16'h8000, 16'h3C00, 16'hBC00,
                  16'hC000, 16'h4000, 16'h4000, 16'hC000};
        exp_q.push_back(16'h3C00);
        exp_q.push_back(16'h4000);
        job("post_rst", 8'd2, 32'd2, 8, 2, 13);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/maxpool.md
# maxpool

Max-pooling engine downstream of the command sequencing block. On `maxpool_ready` it consumes pre-windowed FP16 feature data from the port-0 data FIFO, reduces each window of `kernel_size*kernel_size` elements to its maximum, and pushes one FP16 result per window into the write-back FIFO. After `op_num` windows it raises `maxpool_valid` and holds it until the sequencer drops `maxpool_ready`.

## Interface
- No parameters. Data width is fixed at 16-bit FP16.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `maxpool_ready`  in  1  start/enable level from the sequencer. High starts a job; it stays high until the block returns `maxpool_valid`.
- `kernel_size`  in  8  window edge. Sampled on start.
- `op_num`  in  32  number of output windows. Sampled on start.
- `data_in`  in  16  FP16 element from the data FIFO. Standard-mode FIFO: valid the cycle after `data_fifo_rd_en`.
- `data_fifo_empty`  in  1  data FIFO empty.
- `data_fifo_rd_en`  out  1  data FIFO read strobe.
- `out_fifo_full`  in  1  write-back FIFO full.
- `out_fifo_wr_en`  out  1  write-back FIFO write strobe.
- `data_out`  out  16  FP16 window maximum.
- `maxpool_valid`  out  1  job done. Level, held until `maxpool_ready` is low.

## Operation
- **Reset:** all outputs are 0. State is IDLE and all counters are 0.
- **States:** IDLE, ACCUM, WRITE, DONE.
- **IDLE:**
  - When `maxpool_ready` is high, latch `win_len = kernel_size*kernel_size` (16-bit) and `op_num`, and clear counters.
  - If `win_len==0` or `op_num==0`, go to DONE. Otherwise go to ACCUM.
- **ACCUM:**
  - Assert `data_fifo_rd_en` in any cycle where `!data_fifo_empty` and `rd_issued < win_len`.
  - Each returned element, captured one cycle after its strobe, updates the accumulator. The first element of a window loads it directly.
  - When `rd_recv == win_len`, go to WRITE.
- **WRITE:**
  - Drive `data_out = acc`. Assert `out_fifo_wr_en` for exactly one cycle, in the first cycle with `!out_fifo_full`.
  - Then increment `win_cnt` (32-bit). If `win_cnt+1 == op_num`, go to DONE. Otherwise clear `rd_issued`/`rd_recv` and go to ACCUM.
- **DONE:** `maxpool_valid=1`. When `maxpool_ready` is low, clear `maxpool_valid` and go to IDLE.
- **FP16 max rule (`cand > acc`):**
  - Signs differ: the positive value is larger. +0 and -0 compare equal.
  - Both positive: the larger `[14:0]` wins.
  - Both negative: the smaller `[14:0]` wins.
  - Ties keep `acc`, so the first occurrence wins.
  - NaN/Inf are compared as raw sign-magnitude, with no special-casing.
- **Abort:** `maxpool_ready` falling in ACCUM or WRITE returns the block to IDLE next cycle.
  - `maxpool_valid` is not raised and no further write is issued.
  - Data from an in-flight read is discarded.
- **Reset mid-job:** immediate return to reset values. Partial results are lost.

## Timing
- Throughput is 1 element/cycle while the FIFO is non-empty. There is no overlap between ACCUM of window n+1 and WRITE of window n.
- With `maxpool_ready` rising at cycle 0, FIFO never empty or full, and `win_len=9`:
  - ACCUM runs cycles 1–10. `rd_en` is high cycles 1–9; data is captured cycles 2–10.
  - WRITE is cycle 11, with `out_fifo_wr_en` high in cycle 11.
  - The next window's ACCUM starts in cycle 12. Steady state is 11 cycles/window, i.e. `win_len+2`.
- After the last write, `maxpool_valid` rises one cycle later (DONE entry).
- `data_fifo_empty` gaps stall `rd_en` only. Accumulation resumes without loss.
- `out_fifo_full` holds WRITE with `data_out` stable. The write occurs in the first non-full cycle.
- `data_fifo_rd_en` is never high when `data_fifo_empty` is high. `out_fifo_wr_en` is never high when `out_fifo_full` is high.

## Test plan
- **Single window.** `kernel_size=3`, `op_num=1`, elements 0x3C00, 0x4000, 0x3800, 0x4200, 0x0000, 0xC000, 0x4100, 0x3E00, 0x4400. Required: one write of 0x4400 at cycle 11, `maxpool_valid` high at cycle 12, and the block returns to IDLE the cycle after `maxpool_ready` drops.
- **Sign handling.** Window of all negatives 0xC400, 0xBC00, 0xC000, …. Required: the max is 0xBC00. A window of only 0x8000 and 0x0000 outputs whichever came first.
- **Multi-window with backpressure.** `op_num=4`, `kernel_size=3`, with random `data_fifo_empty` and `out_fifo_full` gaps. Required:
  - Exactly 4 writes, values match the reference model.
  - No read while empty and no write while full.
  - Exactly 36 reads.
- **Degenerate jobs.** `op_num=0`, or `kernel_size=0`. Required: zero reads and zero writes, and `maxpool_valid` high 2 cycles after start.
- **Abort.** Drop `maxpool_ready` mid-ACCUM. Required: IDLE next cycle, no write, no `maxpool_valid`. A new start afterwards runs correctly.
- **Reset mid-job.** Assert `rst_n=0` during WRITE while full. Required: all outputs 0 immediately; after release the block is IDLE and counters are cleared.
